// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device side: host-command receiver, response/packet transmitter.
// Define PS2_DEV_BAT_EN to queue the AA,00 power-on report after reset release.
module ps2_mouse_device #(
    parameter int CLK_HALF = 300,
    parameter int HOLDOFF  = 600
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    inout  wire         ps2_clk,
    inout  wire         ps2_data,
    input  logic        pkt_valid,
    input  logic [23:0] pkt_data,
    output logic        pkt_ready,
    output logic        stream_en,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TX     = 3'd1;
    localparam logic [2:0] S_RX     = 3'd2;
    localparam logic [2:0] S_RX_ACK = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam int CNT_MAX = (HOLDOFF > CLK_HALF) ? HOLDOFF : CLK_HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] HALF_MID  = CW'(CLK_HALF / 2);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);
    // Our own release takes two synchronizer cycles to show up as high.
    localparam logic [CW-1:0] INH_MIN   = CW'(3);

    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          phase_low_reg;
    logic [3:0]    bit_reg;
    logic          clk_low_reg;
    logic          data_low_reg;
    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic [7:0]    tx_byte_reg;
    logic          tx_resp_reg;
    logic [8:0]    rx_shift_reg;
    logic          rx_err_reg;
    logic          rx_stop_reg;
    logic [7:0]    resp_q_reg [3];
    logic [1:0]    resp_cnt_reg;
    logic [23:0]   pkt_reg;
    logic [1:0]    pkt_cnt_reg;
    logic          stream_en_reg;
    logic          cmd_valid_reg;
    logic [7:0]    cmd_byte_reg;
    logic          bat_pending;

    logic          clk_s;
    logic          data_s;
    logic          next_from_resp;
    logic [7:0]    next_byte;
    logic [10:0]   tx_frame;
    logic          rx_good;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    assign next_from_resp = (resp_cnt_reg != 2'd0);
    assign next_byte      = next_from_resp ? resp_q_reg[0] : pkt_reg[7:0];
    assign tx_frame       = {1'b1, ~(^tx_byte_reg), tx_byte_reg, 1'b0};
    assign rx_good        = (^rx_shift_reg) && !rx_err_reg;

    assign ps2_clk  = clk_low_reg  ? 1'b0 : 1'bz;
    assign ps2_data = data_low_reg ? 1'b0 : 1'bz;

    assign pkt_ready = stream_en_reg && (state_reg == S_IDLE) && !bat_pending &&
                       (resp_cnt_reg == 2'd0) && (pkt_cnt_reg == 2'd0);
    assign busy      = (state_reg != S_IDLE) || (resp_cnt_reg != 2'd0) || (pkt_cnt_reg != 2'd0);
    assign stream_en = stream_en_reg;
    assign cmd_valid = cmd_valid_reg;
    assign cmd_byte  = cmd_byte_reg;

`ifdef PS2_DEV_BAT_EN
    logic bat_pending_reg;
    assign bat_pending = bat_pending_reg;
`else
    assign bat_pending = 1'b0;
`endif

    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            phase_low_reg <= 1'b0;
            bit_reg       <= 4'd0;
            clk_low_reg   <= 1'b0;
            data_low_reg  <= 1'b0;
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            tx_byte_reg   <= 8'h00;
            tx_resp_reg   <= 1'b0;
            rx_shift_reg  <= 9'd0;
            rx_err_reg    <= 1'b0;
            rx_stop_reg   <= 1'b0;
            for (int i = 0; i < 3; i++) resp_q_reg[i] <= 8'h00;
            resp_cnt_reg  <= 2'd0;
            pkt_reg       <= 24'd0;
            pkt_cnt_reg   <= 2'd0;
            stream_en_reg <= 1'b0;
            cmd_valid_reg <= 1'b0;
            cmd_byte_reg  <= 8'h00;
`ifdef PS2_DEV_BAT_EN
            bat_pending_reg <= 1'b1;
`endif
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            cmd_valid_reg <= 1'b0;

`ifdef PS2_DEV_BAT_EN
            if (bat_pending_reg) begin
                bat_pending_reg <= 1'b0;
                resp_q_reg[0]   <= 8'hAA;
                resp_q_reg[1]   <= 8'h00;
                resp_cnt_reg    <= 2'd2;
            end
`endif
            if (pkt_valid && pkt_ready) begin
                pkt_reg     <= pkt_data;
                pkt_cnt_reg <= 2'd3;
            end

            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    bit_reg <= 4'd0;
                    if (clk_s && !data_s) begin
                        // Host request-to-send wins over anything queued.
                        state_reg     <= S_RX;
                        clk_low_reg   <= 1'b1;
                        phase_low_reg <= 1'b1;
                        rx_err_reg    <= 1'b0;
                        rx_stop_reg   <= 1'b0;
                    end else if (clk_s && data_s && (next_from_resp || pkt_cnt_reg != 2'd0)) begin
                        state_reg     <= S_TX;
                        tx_byte_reg   <= next_byte;
                        tx_resp_reg   <= next_from_resp;
                        data_low_reg  <= 1'b1;
                        clk_low_reg   <= 1'b0;
                        phase_low_reg <= 1'b0;
                    end
                end

                S_TX: begin
                    if (!phase_low_reg) begin
                        if (bit_reg != 4'd10 && cnt_reg >= INH_MIN && !clk_s) begin
                            // Host inhibit: drop the frame, byte stays queued.
                            clk_low_reg  <= 1'b0;
                            data_low_reg <= 1'b0;
                            cnt_reg      <= '0;
                            state_reg    <= S_HOLD;
                        end else if (cnt_reg == HALF_LAST) begin
                            cnt_reg       <= '0;
                            phase_low_reg <= 1'b1;
                            clk_low_reg   <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (cnt_reg == HALF_LAST) begin
                        cnt_reg       <= '0;
                        phase_low_reg <= 1'b0;
                        clk_low_reg   <= 1'b0;
                        if (bit_reg == 4'd10) begin
                            data_low_reg <= 1'b0;
                            state_reg    <= S_HOLD;
                            if (tx_resp_reg) begin
                                resp_q_reg[0] <= resp_q_reg[1];
                                resp_q_reg[1] <= resp_q_reg[2];
                                resp_cnt_reg  <= resp_cnt_reg - 2'd1;
                            end else begin
                                pkt_reg     <= pkt_reg >> 8;
                                pkt_cnt_reg <= pkt_cnt_reg - 2'd1;
                            end
                        end else begin
                            bit_reg      <= bit_reg + 4'd1;
                            data_low_reg <= ~tx_frame[bit_reg + 4'd1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_RX: begin
                    if (phase_low_reg) begin
                        if (cnt_reg == HALF_LAST) begin
                            cnt_reg       <= '0;
                            phase_low_reg <= 1'b0;
                            clk_low_reg   <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        if (cnt_reg == HALF_MID) begin
                            if (bit_reg < 4'd9)
                                rx_shift_reg <= {data_s, rx_shift_reg[8:1]};
                            else if (data_s)
                                rx_stop_reg <= 1'b1;
                            else
                                rx_err_reg <= 1'b1;
                        end
                        if (cnt_reg == HALF_LAST) begin
                            cnt_reg       <= '0;
                            phase_low_reg <= 1'b1;
                            clk_low_reg   <= 1'b1;
                            if (rx_stop_reg) begin
                                state_reg    <= S_RX_ACK;
                                data_low_reg <= 1'b1;
                            end else if (bit_reg != 4'd9) begin
                                bit_reg <= bit_reg + 4'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                S_RX_ACK: begin
                    if (cnt_reg != HALF_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (phase_low_reg) begin
                        cnt_reg       <= '0;
                        phase_low_reg <= 1'b0;
                        clk_low_reg   <= 1'b0;
                    end else begin
                        cnt_reg      <= '0;
                        data_low_reg <= 1'b0;
                        state_reg    <= S_HOLD;
                        // Any new command discards unsent responses and packet bytes.
                        pkt_cnt_reg  <= 2'd0;
                        resp_cnt_reg <= 2'd1;
                        if (rx_good) begin
                            cmd_byte_reg  <= rx_shift_reg[7:0];
                            cmd_valid_reg <= 1'b1;
                            resp_q_reg[0] <= 8'hFA;
                            case (rx_shift_reg[7:0])
                                8'hF4: stream_en_reg <= 1'b1;
                                8'hF5: stream_en_reg <= 1'b0;
                                8'hFF: begin
                                    stream_en_reg <= 1'b0;
                                    resp_q_reg[1] <= 8'hAA;
                                    resp_q_reg[2] <= 8'h00;
                                    resp_cnt_reg  <= 2'd3;
                                end
                                default: ;
                            endcase
                        end else begin
                            resp_q_reg[0] <= 8'hFE;
                        end
                    end
                end

                S_HOLD: begin
                    if (!clk_s)
                        cnt_reg <= '0;
                    else if (cnt_reg == HOLD_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else
                        cnt_reg <= cnt_reg + 1'b1;
                end

                default: begin
                    state_reg    <= S_IDLE;
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ps2_mouse_device.md
PS2_MOUSE_DEVICE -- requirements
Module: ps2_mouse_device

Interface
REQ-001 SHALL have parameter CLK_HALF, default 300, ps2_clk half-period in clk_12MHz cycles (20 kHz bit clock).
REQ-002 SHALL have parameter HOLDOFF, default 600, minimum idle clk_12MHz cycles between device frames.
REQ-003 SHALL have ports:
- clk_12MHz  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- ps2_clk  inout  1  open-collector clock: drives 0 or z
- ps2_data  inout  1  open-collector data: drives 0 or z
- pkt_valid  input  1  movement packet offered
- pkt_data  input  24  byte0 = [7:0], byte1 = [15:8], byte2 = [23:16]
- pkt_ready  output  1  packet accepted when pkt_valid and pkt_ready are both high on a rising edge
- stream_en  output  1  data reporting enabled
- cmd_valid  output  1  one-cycle pulse for each received host byte
- cmd_byte  output  8  last received host byte
- busy  output  1  frame in progress or bytes queued

Function
REQ-004 SHALL sample ps2_clk and ps2_data through two-flop synchronizers before any use.
REQ-005 SHALL implement states IDLE, TX, RX, RX_ACK and HOLD.
REQ-006 In TX, SHALL send 11 bits: start 0, data LSB first, odd parity, stop 1.
REQ-007 TX bit timing SHALL be: data set at the start of the clock-high phase; ps2_clk released for CLK_HALF cycles; ps2_clk pulled low for CLK_HALF cycles.
REQ-008 In TX, if synchronized ps2_clk reads low during a device-released high phase (host inhibit) before the stop bit, SHALL release both lines, abort, keep the byte queued, and enter HOLD.
REQ-009 In IDLE, synchronized ps2_clk high and ps2_data low (host request-to-send) SHALL enter RX; host request SHALL take priority over a pending TX.
REQ-010 In RX, SHALL generate 10 clock pulses and sample ps2_data at mid-high phase: 8 data bits, parity, stop.
REQ-011 In RX_ACK, SHALL drive ps2_data low for one full clock pulse, then release it.
REQ-012 After RX_ACK, SHALL update cmd_byte and pulse cmd_valid one cycle.
REQ-013 Command handling SHALL be:
- F4: queue FA; stream_en=1.
- F5: queue FA; stream_en=0.
- FF: queue FA, AA, 00; stream_en=0.
- any other byte: queue FA.
- parity error: queue FE only; no cmd_valid; stream_en unchanged.
REQ-014 Response queue SHALL hold 3 bytes; a new command SHALL flush earlier unsent responses and any partially sent packet.
REQ-015 pkt_ready SHALL be high only when stream_en=1, the state is IDLE, and both queues are empty.
REQ-016 An accepted packet SHALL be sent as byte0, byte1, byte2; response bytes SHALL preempt packet bytes only at a byte boundary.
REQ-017 A missing stop bit (stop=0) in RX SHALL be treated as a parity error; the device SHALL keep clocking until ps2_data reads high, then ACK.
REQ-018 HOLD SHALL wait until ps2_clk has been high for HOLDOFF cycles, then return to IDLE.
REQ-019 busy SHALL be high in any state other than IDLE, or while any byte is queued.

Reset
REQ-020 While reset=0, SHALL release ps2_clk and ps2_data (z) and enter IDLE, with queues empty and outputs: stream_en=0, cmd_valid=0, cmd_byte=00, pkt_ready=0, busy=0.
REQ-021 Reset assertion mid-frame SHALL abort immediately; no partial byte is resumed.

Configuration
REQ-022 Macro PS2_DEV_BAT_EN defined: after reset release, SHALL queue AA then 00, and pkt_ready SHALL stay 0 until both bytes are sent.
REQ-023 Macro PS2_DEV_BAT_EN undefined: SHALL stay silent after reset release until the first host command.

Verification
REQ-024 Host sends F4 with correct parity -> cmd_valid pulse with cmd_byte=F4, ACK low pulse seen, then device frame FA; stream_en=1.
REQ-025 With stream_en=1, pkt_data=0x050A09 with pkt_valid=1 -> frames 09, 0A, 05 in order, each with odd parity and ≥HOLDOFF gap.
REQ-026 Host pulls ps2_clk low during bit 4 of the 0A frame -> abort; 0A then 05 are resent complete after release plus HOLDOFF.
REQ-027 Host sends F4 with bad parity -> no cmd_valid, device sends FE, stream_en unchanged.
REQ-028 Host sends FF -> device sends FA, AA, 00; stream_en=0; pkt_ready=0.
REQ-029 reset pulsed low mid-TX -> both lines z within 1 cycle; with PS2_DEV_BAT_EN, AA then 00 sent after release.
